// File: rtl/data_mem_lsu_if.sv
`default_nettype none
// ============================================================================
// Module      : memory_if
// Description : Single-port byte-lane memory bank interface (addr, wdata, wr, rdata).
// Revision    : 1.0 - initial release
// ============================================================================
interface memory_if #(
    parameter int AW = 9,
    parameter int DW = 8
);
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          wr;
    logic [DW-1:0] rdata;

    modport master (output addr, output wdata, output wr, input rdata);
    modport slave  (input addr, input wdata, input wr, output rdata);
endinterface
`default_nettype wire

// File: rtl/data_mem_lsu.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_lsu
// Description : Byte/half/word load-store front end over four byte-lane banks.
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_lsu #(
    parameter int AW               = 9,
    parameter int ALLOW_MISALIGNED = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    memory_if.master    bank_if [0:3]
);
    localparam logic [1:0] c_SZ_BYTE = 2'b00;
    localparam logic [1:0] c_SZ_HALF = 2'b01;
    localparam logic [1:0] c_SZ_WORD = 2'b10;
    localparam logic [1:0] c_SZ_BAD  = 2'b11;

    logic          r_rsp_valid;
    logic [31:0]   r_rsp_rdata;
    logic          r_rsp_err;

    logic [1:0]    w_off;
    logic [2:0]    w_nbytes;
    logic [AW-1:0] w_widx;
    logic          w_hi_bad;
    logic          w_misal;
    logic          w_err;
    logic          w_accept;
    logic [7:0]    w_lane_rdata [4];
    logic [31:0]   w_raw;
    logic [31:0]   w_ext;

    assign w_off  = req_addr[1:0];
    assign w_widx = req_addr[AW+1:2];

    always_comb begin
        w_nbytes = 3'd4;
        case (req_size)
            c_SZ_BYTE: w_nbytes = 3'd1;
            c_SZ_HALF: w_nbytes = 3'd2;
            default:   w_nbytes = 3'd4;
        endcase
    end

    if (AW + 2 < 32) begin : g_hi_chk
        assign w_hi_bad = |req_addr[31:AW+2];
    end else begin : g_no_hi_chk
        assign w_hi_bad = 1'b0;
    end

    assign w_misal = ((req_size == c_SZ_HALF) && req_addr[0]) ||
                     ((req_size == c_SZ_WORD) && (w_off != 2'b00));
    assign w_err   = (req_size == c_SZ_BAD) || w_hi_bad ||
                     ((ALLOW_MISALIGNED == 0) && w_misal);

    assign req_ready = !rst && (!r_rsp_valid || rsp_ready);
    assign w_accept  = req_valid && req_ready;

    // Lanes below the offset hold the spill-over bytes, so they sit one word higher.
    for (genvar i = 0; i < 4; i++) begin : g_lane
        logic [1:0] w_rel;
        logic       w_bump;

        assign w_rel            = 2'(i) - w_off;
        assign w_bump           = (2'(i) < w_off);
        assign bank_if[i].addr  = w_widx + AW'(w_bump);
        assign bank_if[i].wdata = req_wdata[8*w_rel +: 8];
        assign bank_if[i].wr    = w_accept && req_wr && !w_err &&
                                  ({1'b0, w_rel} < w_nbytes);
        assign w_lane_rdata[i]  = bank_if[i].rdata;
    end

    always_comb begin
        w_raw = '0;
        for (int k = 0; k < 4; k++) begin
            w_raw[8*k +: 8] = w_lane_rdata[w_off + 2'(k)];
        end
    end

    always_comb begin
        w_ext = w_raw;
        case (req_size)
            c_SZ_BYTE: w_ext = {{24{w_raw[7] & ~req_unsigned}}, w_raw[7:0]};
            c_SZ_HALF: w_ext = {{16{w_raw[15] & ~req_unsigned}}, w_raw[15:0]};
            default:   w_ext = w_raw;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else if (w_accept) begin
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= w_err;
            r_rsp_rdata <= (w_err || req_wr) ? 32'd0 : w_ext;
        end else if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
endmodule
`default_nettype wire

// File: tb/tb_data_mem_lsu.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_mem_lsu
// Description : Directed + random bench for data_mem_lsu against a flat byte-memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_lsu;
    localparam int AW   = 9;
    localparam int WDS  = 1 << AW;
    localparam int MEMB = 4 * WDS;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_wr, req_unsigned, rsp_ready;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic        req_ready_m, rsp_valid_m, rsp_err_m;
    logic        req_ready_s, rsp_valid_s, rsp_err_s;
    logic [31:0] rsp_rdata_m, rsp_rdata_s;

    always #5 clk = ~clk;

    memory_if #(.AW(AW), .DW(8)) bif_m [0:3] ();
    memory_if #(.AW(AW), .DW(8)) bif_s [0:3] ();

    data_mem_lsu #(.AW(AW), .ALLOW_MISALIGNED(1)) u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready_m),
        .req_wr(req_wr), .req_addr(req_addr), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid_m), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata_m),
        .rsp_err(rsp_err_m), .bank_if(bif_m)
    );

    data_mem_lsu #(.AW(AW), .ALLOW_MISALIGNED(0)) u_strict (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready_s),
        .req_wr(req_wr), .req_addr(req_addr), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid_s), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata_s),
        .rsp_err(rsp_err_s), .bank_if(bif_s)
    );

    // Bank storage for both instances: lane i, word w
    logic [7:0]             bmem_m [0:3][0:WDS-1];
    logic [7:0]             bmem_s [0:3][0:WDS-1];
    logic [3:0]             wr_m, wr_s;
    logic [3:0][AW-1:0]     addr_m, addr_s;
    logic [3:0][7:0]        wd_m, wd_s;

    for (genvar i = 0; i < 4; i++) begin : g_bank
        assign wr_m[i]        = bif_m[i].wr;
        assign addr_m[i]      = bif_m[i].addr;
        assign wd_m[i]        = bif_m[i].wdata;
        assign bif_m[i].rdata = bmem_m[i][addr_m[i]];
        assign wr_s[i]        = bif_s[i].wr;
        assign addr_s[i]      = bif_s[i].addr;
        assign wd_s[i]        = bif_s[i].wdata;
        assign bif_s[i].rdata = bmem_s[i][addr_s[i]];
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (wr_m[i]) bmem_m[i][addr_m[i]] <= wd_m[i];
            if (wr_s[i]) bmem_s[i][addr_s[i]] <= wd_s[i];
        end
    end

    // Reference: flat byte-addressed memories, one per instance
    logic [7:0]  ref_m [MEMB];
    logic [7:0]  ref_s [MEMB];
    int          n_pass  = 0;
    int          n_total = 0;
    logic [31:0] last_m;

    function automatic void model(input bit sel_strict, input bit wr, input logic [31:0] addr,
                                  input logic [1:0] size, input bit uns, input logic [31:0] wdata,
                                  output bit err, output logic [31:0] rdata);
        int          n;
        int          a;
        logic [31:0] v;
        n     = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        v     = 32'd0;
        rdata = 32'd0;
        err   = (size == 2'd3) || (addr >= 32'(MEMB)) || (sel_strict && (addr % 32'(n) != 0));
        if (err) return;
        for (int k = 0; k < n; k++) begin
            a = int'((addr + 32'(k)) % 32'(MEMB));
            if (wr) begin
                if (sel_strict) ref_s[a] = wdata[8*k +: 8];
                else            ref_m[a] = wdata[8*k +: 8];
            end else begin
                v[8*k +: 8] = sel_strict ? ref_s[a] : ref_m[a];
            end
        end
        if (!wr) begin
            if (n == 1)      rdata = uns ? v : 32'($signed(v[7:0]));
            else if (n == 2) rdata = uns ? v : 32'($signed(v[15:0]));
            else             rdata = v;
        end
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Presents one request with rsp_ready high and checks its response one cycle later.
    task automatic do_req(input string tag, input bit wr, input logic [31:0] addr,
                          input logic [1:0] size, input bit uns, input logic [31:0] wdata);
        bit          em, es;
        logic [31:0] dm, ds;
        req_valid = 1'b1; req_wr = wr; req_addr = addr; req_size = size;
        req_unsigned = uns; req_wdata = wdata; rsp_ready = 1'b1;
        #1;
        check({tag, " req_ready"}, 32'(req_ready_m), 32'd1);
        model(1'b0, wr, addr, size, uns, wdata, em, dm);
        model(1'b1, wr, addr, size, uns, wdata, es, ds);
        @(posedge clk); #1;
        check({tag, " rsp_valid"}, 32'(rsp_valid_m), 32'd1);
        check({tag, " rdata"}, rsp_rdata_m, dm);
        check({tag, " err"}, 32'(rsp_err_m), 32'(em));
        check({tag, " strict rdata"}, rsp_rdata_s, ds);
        check({tag, " strict err"}, 32'(rsp_err_s), 32'(es));
        last_m = dm;
    endtask

    initial begin
        logic [31:0] a;
        rst = 1'b1; req_valid = 1'b1; req_wr = 1'b1; req_addr = 32'h40;
        req_size = 2'd2; req_unsigned = 1'b0; req_wdata = 32'h0BADF00D; rsp_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("reset rsp_valid", 32'(rsp_valid_m), 32'd0);
        check("reset rdata", rsp_rdata_m, 32'd0);
        check("reset err", 32'(rsp_err_m), 32'd0);
        check("reset req_ready", 32'(req_ready_m), 32'd0);
        check("reset bank wr", 32'(wr_m), 32'd0);
        rst = 1'b0; req_valid = 1'b0;
        #1;
        check("post-reset req_ready", 32'(req_ready_m), 32'd1);

        for (int w = 0; w < WDS; w++) do_req("preload", 1'b1, 32'(w * 4), 2'd2, 1'b0, $urandom);

        do_req("st_w", 1'b1, 32'h010, 2'd2, 1'b0, 32'hDEADBEEF);
        do_req("ld_w", 1'b0, 32'h010, 2'd2, 1'b0, 32'h0);
        check("ld_w const", rsp_rdata_m, 32'hDEADBEEF);
        do_req("ld_bs", 1'b0, 32'h013, 2'd0, 1'b0, 32'h0);
        check("ld_bs const", rsp_rdata_m, 32'hFFFFFFDE);
        do_req("ld_bu", 1'b0, 32'h013, 2'd0, 1'b1, 32'h0);
        check("ld_bu const", rsp_rdata_m, 32'h000000DE);
        do_req("ld_hs", 1'b0, 32'h012, 2'd1, 1'b0, 32'h0);
        check("ld_hs const", rsp_rdata_m, 32'hFFFFDEAD);

        do_req("st_wrap", 1'b1, 32'h7FE, 2'd2, 1'b0, 32'h11223344);
        check("wrap 7FE", 32'(bmem_m[2][WDS-1]), 32'h44);
        check("wrap 7FF", 32'(bmem_m[3][WDS-1]), 32'h33);
        check("wrap 000", 32'(bmem_m[0][0]), 32'h22);
        check("wrap 001", 32'(bmem_m[1][0]), 32'h11);
        do_req("ld_wrap", 1'b0, 32'h7FE, 2'd2, 1'b0, 32'h0);
        check("ld_wrap const", rsp_rdata_m, 32'h11223344);

        do_req("err_size", 1'b1, 32'h040, 2'd3, 1'b0, 32'h12345678);
        check("err_size flag", 32'(rsp_err_m), 32'd1);
        do_req("err_size chk", 1'b0, 32'h040, 2'd2, 1'b0, 32'h0);
        do_req("err_range", 1'b1, 32'h800, 2'd2, 1'b0, 32'h12345678);
        check("err_range flag", 32'(rsp_err_m), 32'd1);
        do_req("err_range chk", 1'b0, 32'h000, 2'd2, 1'b0, 32'h0);
        do_req("err_mis", 1'b1, 32'h005, 2'd1, 1'b0, 32'h0000A5A5);
        check("err_mis strict flag", 32'(rsp_err_s), 32'd1);
        do_req("err_mis chk", 1'b0, 32'h004, 2'd2, 1'b0, 32'h0);

        for (int i = 0; i < 8; i++) do_req("b2b", i[0], 32'h080 + 32'(4 * (i / 2)), 2'd2, 1'b0, $urandom);

        for (int i = 0; i < 300; i++) begin
            a = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, MEMB - 1));
            do_req("rand", 1'($urandom_range(0, 1)), a,
                   ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2)),
                   1'($urandom_range(0, 1)), $urandom);
        end

        // Backpressure: pending load held while a store waits
        do_req("bp_ld", 1'b0, 32'h100, 2'd2, 1'b0, 32'h0);
        rsp_ready = 1'b0; req_valid = 1'b1; req_wr = 1'b1; req_addr = 32'h104;
        req_size = 2'd2; req_wdata = 32'hCAFEF00D;
        #1;
        check("bp req_ready", 32'(req_ready_m), 32'd0);
        check("bp bank wr", 32'(wr_m), 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check("bp hold valid", 32'(rsp_valid_m), 32'd1);
            check("bp hold rdata", rsp_rdata_m, last_m);
            check("bp hold req_ready", 32'(req_ready_m), 32'd0);
            check("bp hold bank wr", 32'(wr_m), 32'd0);
        end
        rsp_ready = 1'b1;
        #1;
        check("bp release req_ready", 32'(req_ready_m), 32'd1);
        begin
            bit          e;
            logic [31:0] d;
            model(1'b0, 1'b1, 32'h104, 2'd2, 1'b0, 32'hCAFEF00D, e, d);
            model(1'b1, 1'b1, 32'h104, 2'd2, 1'b0, 32'hCAFEF00D, e, d);
        end
        @(posedge clk); #1;
        check("bp next valid", 32'(rsp_valid_m), 32'd1);
        check("bp next rdata", rsp_rdata_m, 32'd0);
        check("bp next err", 32'(rsp_err_m), 32'd0);
        do_req("bp_ld2", 1'b0, 32'h104, 2'd2, 1'b0, 32'h0);
        check("bp_ld2 const", rsp_rdata_m, 32'hCAFEF00D);

        // Reset with a pending response and a store presented
        do_req("rs_ld", 1'b0, 32'h024, 2'd2, 1'b0, 32'h0);
        rst = 1'b1; rsp_ready = 1'b0; req_valid = 1'b1; req_wr = 1'b1;
        req_addr = 32'h020; req_size = 2'd2; req_wdata = 32'h55AA55AA;
        #1;
        check("rs bank wr", 32'(wr_m), 32'd0);
        check("rs req_ready", 32'(req_ready_m), 32'd0);
        @(posedge clk); #1;
        check("rs rsp_valid", 32'(rsp_valid_m), 32'd0);
        check("rs rdata", rsp_rdata_m, 32'd0);
        rst = 1'b0; req_valid = 1'b0;
        #1;
        check("rs after req_ready", 32'(req_ready_m), 32'd1);
        do_req("rs_chk", 1'b0, 32'h020, 2'd2, 1'b0, 32'h0);

        req_valid = 1'b0;
        @(posedge clk); #1;
        check("idle rsp_valid", 32'(rsp_valid_m), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/data_mem_lsu.md
# data_mem_lsu

Load/store front end for the CPU data memory. Accepts one byte/half/word load or store per cycle from the execute stage over a valid/ready handshake. Drives four byte-wide `sub_data_memory` banks (lanes 0-3, byte address bits [1:0]) through their `memory_if` slave ports, and returns a registered, sign/zero-extended response one cycle later. Misaligned accesses complete in a single access by giving each bank its own word address.

## Interface
- `AW`, 9: per-bank word address width; memory size is 4·2^AW bytes (2048 bytes by default).
- `ALLOW_MISALIGNED`, 1: 1 executes misaligned accesses; 0 flags them as errors.

- `clk`  in  1  single clock; everything is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted this cycle when high together with `req_valid`.
- `req_wr`  in  1  1 = store, 0 = load.
- `req_addr`  in  32  byte address.
- `req_size`  in  2  access size: 00 byte, 01 half, 10 word, 11 illegal.
- `req_unsigned`  in  1  load zero-extends when 1, sign-extends when 0; ignored for stores.
- `req_wdata`  in  32  store data, LSB-aligned.
- `rsp_valid`  out  1  response held in the output register.
- `rsp_ready`  in  1  consumer takes the response.
- `rsp_rdata`  out  32  extended load data; 0 for stores and errors.
- `rsp_err`  out  1  access rejected.
- `bank_if[0:3]`  memory_if.master  addr AW / data 8  byte-lane bank ports (addr, wdata, wr, rdata).

## Operation
- Decode: `o` = addr[1:0]; `n` = 1, 2 or 4 bytes; `widx` = addr[AW+1:2].
- Error conditions: `req_size`=11; addr[31:AW+2] ≠ 0; or `ALLOW_MISALIGNED`=0 with a misaligned access (half with addr[0]=1, word with addr[1:0] ≠ 0).
- On error: no bank write, `rsp_err`=1, `rsp_rdata`=0.
- Lane mapping: access byte k (0..n-1) uses lane (o+k) mod 4.
- Bank i is addressed at (widx + (i<o ? 1 : 0)) mod 2^AW. A crossing of the top word therefore wraps to word 0. This is legal and is not an error.
- Bank i `wdata` = req_wdata byte ((i−o) mod 4). Bank i `wr` = accept & req_wr & !err & ((i−o) mod 4 < n).
- Bank `addr`/`wdata` are driven combinationally from the request at all times; only `wr` is qualified.
- Load data: byte k = bank[(o+k) mod 4].rdata, sampled combinationally in the accept cycle and assembled LSB-first.
- Load extension: byte or half is extended from bit 7 or bit 15 according to `req_unsigned`; a word is passed through.
- Stores also produce a response (an ack with `rsp_rdata`=0) so the pipeline retires them in order.
- Output register: on accept, load `rsp_valid`=1, `rsp_rdata`, `rsp_err`. Otherwise, if `rsp_ready`, clear `rsp_valid`. Data and error hold while `rsp_valid` is high and `rsp_ready` is low.

## Timing
- `req_ready` = !rst & (!rsp_valid | rsp_ready). This allows full throughput of one access per cycle under continuous `rsp_ready`.
- Accept occurs at the edge where `req_valid` & `req_ready`. A store's bank writes commit at that same edge.
- Latency: response valid in the cycle after accept.
- Load-after-store to the same bytes in the next cycle returns the new data, because the banks read combinationally after the write edge.
- Simultaneous accept and `rsp_ready` with `rsp_valid`=1: the old response retires and the new one loads in the same edge, so no bubble is inserted.
- Reset values: `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, `req_ready`=0, all bank `wr`=0.
- Reset asserted while a response is pending discards the response. A request presented during reset is not accepted and causes no write.
- Bank contents are not reset.

## Test plan
- Aligned word: store 0xDEADBEEF at 0x010. Then load word at 0x010 → 0xDEADBEEF. Load byte signed at 0x013 → 0xFFFFFFDE. Load byte unsigned at 0x013 → 0x000000DE. Load half signed at 0x012 → 0xFFFFDEAD.
- Misaligned wrap (AW=9): store word 0x11223344 at 0x7FE. Bytes must land as 0x44 at 0x7FE, 0x33 at 0x7FF, 0x22 at 0x000, 0x11 at 0x001. Load word at 0x7FE → 0x11223344, `rsp_err`=0.
- Errors: each of the following gives `rsp_err`=1, `rsp_rdata`=0 and leaves memory unchanged:
  - `req_size`=11;
  - addr 0x00000800;
  - with `ALLOW_MISALIGNED`=0, a half access at 0x005.
- Back-to-back throughput: 8 consecutive requests with `rsp_ready`=1 → 8 responses on consecutive cycles, in order, each one cycle after its accept.
- Backpressure: hold `rsp_ready`=0 for 3 cycles with a pending load → `req_ready`=0 and `rsp_rdata` is stable. Release → the response retires and the next request is accepted in the same edge.
- Reset mid-traffic: assert `rst` for one cycle with a pending response and a valid store at 0x020 → `rsp_valid`=0, no write at 0x020, and `req_ready`=1 in the cycle after reset deasserts.
